// File: rtl/aie_stream_chain.sv
// Linear chain of NUM_TILES stream tiles: each tile is a FIFO feeding one registered
// compute stage with a runtime-configurable opcode, immediate and accumulator.
module aie_stream_chain #(
    parameter int unsigned NUM_TILES  = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned TW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  cfg_we,
    input  logic [TW-1:0]         cfg_tile,
    input  logic [1:0]            cfg_op,
    input  logic [DATA_WIDTH-1:0] cfg_imm,
    output logic                  busy
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        OpPass  = 2'd0,
        OpAdd   = 2'd1,
        OpMul   = 2'd2,
        OpAccum = 2'd3
    } op_e;

    logic                  full_a   [NUM_TILES];
    logic                  active_a [NUM_TILES];
    logic                  rvalid_a [NUM_TILES];
    logic [DATA_WIDTH-1:0] rdata_a  [NUM_TILES];

    for (genvar i = 0; i < NUM_TILES; i++) begin : g_tile
        logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
        logic [AW-1:0]         wptr;
        logic [AW-1:0]         rptr;
        logic [CW-1:0]         count;
        logic                  full;
        logic                  empty;
        logic                  up_valid;
        logic                  down_ready;
        logic                  push;
        logic                  load;
        logic                  cfg_hit;
        logic [DATA_WIDTH-1:0] up_data;
        logic [DATA_WIDTH-1:0] x;
        logic [DATA_WIDTH-1:0] result;
        logic [DATA_WIDTH-1:0] imm;
        logic [DATA_WIDTH-1:0] acc;
        logic [DATA_WIDTH-1:0] r_data;
        logic                  r_valid;
        op_e                   op;

        if (i == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = in_data;
        end else begin : g_link
            assign up_valid = rvalid_a[i-1];
            assign up_data  = rdata_a[i-1];
        end

        if (i == NUM_TILES - 1) begin : g_tail
            assign down_ready = out_ready;
        end else begin : g_mid
            assign down_ready = !full_a[i+1];
        end

        // Full ignores a same-cycle pop, so ready never combinationally depends on downstream.
        assign full    = (count == CW'(FIFO_DEPTH));
        assign empty   = (count == '0);
        assign push    = up_valid && !full;
        assign load    = !empty && (!r_valid || down_ready);
        assign cfg_hit = cfg_we && (cfg_tile == TW'(i));
        assign x       = mem[rptr];

        always_comb begin
            result = x;
            unique case (op)
                OpPass:  result = x;
                OpAdd:   result = x + imm;
                OpMul:   result = x * imm;
                OpAccum: result = acc + x;
            endcase
        end

        always_ff @(posedge clk) begin
            if (push) begin
                mem[wptr] <= up_data;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    wptr <= wptr + AW'(1);
                end
                if (load) begin
                    rptr <= rptr + AW'(1);
                end
                if (push && !load) begin
                    count <= count + CW'(1);
                end else if (!push && load) begin
                    count <= count - CW'(1);
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else if (load) begin
                r_valid <= 1'b1;
                r_data  <= result;
            end else if (down_ready) begin
                r_valid <= 1'b0;
            end
        end

        // A config write takes effect after this edge; a word loading now still sees old op/imm.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                op  <= OpPass;
                imm <= '0;
                acc <= '0;
            end else if (cfg_hit) begin
                op  <= op_e'(cfg_op);
                imm <= cfg_imm;
                acc <= '0;
            end else if (load && op == OpAccum) begin
                acc <= acc + x;
            end
        end

        assign full_a[i]   = full;
        assign active_a[i] = !empty || r_valid;
        assign rvalid_a[i] = r_valid;
        assign rdata_a[i]  = r_data;
    end

    assign in_ready  = !full_a[0];
    assign out_valid = rvalid_a[NUM_TILES-1];
    assign out_data  = rdata_a[NUM_TILES-1];

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < NUM_TILES; k++) begin
            busy = busy | active_a[k];
        end
    end

endmodule

// File: tb/tb_aie_stream_chain.sv
// Directed bench for aie_stream_chain with default parameters (4 tiles, 8-bit, depth 4).
module tb_aie_stream_chain;
    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       cfg_we;
    logic [1:0] cfg_tile;
    logic [1:0] cfg_op;
    logic [7:0] cfg_imm;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    aie_stream_chain #(
        .NUM_TILES (4),
        .DATA_WIDTH(8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .cfg_we   (cfg_we),
        .cfg_tile (cfg_tile),
        .cfg_op   (cfg_op),
        .cfg_imm  (cfg_imm),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic push(input logic [7:0] d);
        int k;
        in_valid = 1'b1;
        in_data  = d;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("push_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] exp);
        for (int k = 0; k < 40 && !out_valid; k++) @(negedge clk);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_data"}, out_data, exp);
        @(negedge clk);
    endtask

    task automatic cfg(input logic [1:0] tile, input logic [1:0] op, input logic [7:0] imm);
        cfg_we   = 1'b1;
        cfg_tile = tile;
        cfg_op   = op;
        cfg_imm  = imm;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int         v;
        logic       rdy;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        cfg_we    = 1'b0;
        cfg_tile  = '0;
        cfg_op    = '0;
        cfg_imm   = '0;

        // T1: reset state and single-word latency
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        push(8'h12);
        chk("t1_busy_flight", busy, 1);
        repeat (6) @(negedge clk);
        chk("t1_valid_edge6", out_valid, 0);
        @(negedge clk);
        chk("t1_valid_edge7", out_valid, 1);
        chk("t1_data", out_data, 8'h12);
        @(negedge clk);
        chk("t1_taken_valid", out_valid, 0);
        chk("t1_idle_busy", busy, 0);

        // T2: ADD then MUL with wrap
        cfg(2'd0, 2'd1, 8'h05);
        cfg(2'd1, 2'd2, 8'h03);
        push(8'h10);
        expect_out("t2_a", 8'h3F);
        push(8'h60);
        expect_out("t2_b", 8'h2F);

        // T3: fill to capacity with out_ready low, then drain
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        v = 0;
        for (int c = 0; c < 80 && v < 31; c++) begin
            in_data = 8'(v);
            rdy = in_ready;
            @(negedge clk);
            if (rdy) v++;
        end
        in_valid = 1'b0;
        chk("t3_accepted", v, 20);
        chk("t3_in_ready_low", in_ready, 0);
        repeat (3) @(negedge clk);
        chk("t3_in_ready_held", in_ready, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            chk("t3_drain_valid", out_valid, 1);
            chk("t3_drain_data", out_data, k);
            @(negedge clk);
        end
        chk("t3_empty_valid", out_valid, 0);
        chk("t3_empty_busy", busy, 0);

        // T4: accumulate on the last tile, then clear by config rewrite
        cfg(2'd3, 2'd3, 8'h00);
        push(8'd1);
        push(8'd2);
        push(8'd3);
        expect_out("t4_1", 8'd1);
        expect_out("t4_2", 8'd3);
        expect_out("t4_3", 8'd6);
        cfg(2'd3, 2'd3, 8'h00);
        push(8'd4);
        expect_out("t4_4", 8'd4);

        // T5: config write on the same edge tile 0 loads a word
        do_reset();
        push(8'h20);
        cfg(2'd0, 2'd1, 8'h01);
        expect_out("t5_old_cfg", 8'h20);
        push(8'h20);
        expect_out("t5_new_cfg", 8'h21);

        // T6: reset while ten words are in flight
        do_reset();
        cfg(2'd2, 2'd1, 8'h07);
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) push(8'(8'h30 + k));
        repeat (20) @(negedge clk);
        chk("t6_pre_valid", out_valid, 1);
        chk("t6_pre_data", out_data, 8'h37);
        chk("t6_pre_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_in_ready", in_ready, 1);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t6_after_valid", out_valid, 0);
        push(8'hAA);
        expect_out("t6_pass", 8'hAA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL tb_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
